// File: rtl/comp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state
// encoding and the 3-bit result word {M, igual, m}.
package comp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

    // Packs the three comparator flags into the shared result encoding.
    function automatic logic [2:0] packResult(input logic gt, input logic eq, input logic lt);
        return {gt, eq, lt};
    endfunction

endpackage

// File: rtl/comp_chunk.sv
// Combinational CHUNK-bit unsigned magnitude comparator used by comp_serie
// to judge one slice of the operands per clock cycle.
module comp_chunk
    import comp_pkg::*;
#(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             M,
    output logic             igual,
    output logic             m
);

    // Exactly one flag is high for any pair of inputs.
    always_comb begin
        M     = (a > b);
        igual = (a == b);
        m     = (a < b);
    end

endmodule

// File: rtl/comp_serie.sv
// Serial magnitude comparator: walks the captured operands CHUNK bits per
// cycle, MSB chunk first, and stops at the first differing chunk.
// Optional feature: define COMP_SIGNED_EN to compare the operands as two's
// complement (the sign bit of both operands is inverted on capture, so the
// unsigned chunk walk orders signed values correctly at no latency cost).
module comp_serie
    import comp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             M,
    output logic             igual,
    output logic             m
);

    localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

`ifdef COMP_SIGNED_EN
    localparam logic [WIDTH-1:0] SIGN_FLIP = WIDTH'(1) << (WIDTH - 1);
`else
    localparam logic [WIDTH-1:0] SIGN_FLIP = '0;
`endif

    // Reject operand widths that cannot be split into whole chunks.
    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_badCfg
            $error("comp_serie: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t           r_state;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [IDXW-1:0]  r_idx;
    logic             r_busy;
    logic             r_done;
    logic [2:0]       r_res;

    logic [CHUNK-1:0] w_chunkA;
    logic [CHUNK-1:0] w_chunkB;
    logic             w_chunkGt;
    logic             w_chunkEq;
    logic             w_chunkLt;
    logic [2:0]       w_chunkRes;

    // Select the chunk pointed to by the current index.
    always_comb begin
        w_chunkA   = r_opA[int'(r_idx) * CHUNK +: CHUNK];
        w_chunkB   = r_opB[int'(r_idx) * CHUNK +: CHUNK];
        w_chunkRes = packResult(w_chunkGt, w_chunkEq, w_chunkLt);
    end

    comp_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a     (w_chunkA),
        .b     (w_chunkB),
        .M     (w_chunkGt),
        .igual (w_chunkEq),
        .m     (w_chunkLt)
    );

    // Control FSM with registered busy/done/result; a differing chunk or the last equal chunk ends the walk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_opA   <= '0;
            r_opB   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_res   <= RES_NONE;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_opA   <= a ^ SIGN_FLIP;
                        r_opB   <= b ^ SIGN_FLIP;
                        r_idx   <= IDX_LAST;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!w_chunkEq || r_idx == '0) begin
                        r_res   <= w_chunkRes;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign M     = r_res[2];
    assign igual = r_res[1];
    assign m     = r_res[0];

endmodule

// File: tb/tb_comp_serie.sv
// Scoreboard bench for comp_serie (WIDTH=8, CHUNK=2). Stimulus pushes the
// hand-computed result and latency; a negedge monitor pops on every done.
// Expected values follow COMP_SIGNED_EN when the macro is defined.
module tb_comp_serie;

    localparam logic [2:0] E_GT = 3'b100;
    localparam logic [2:0] E_EQ = 3'b010;
    localparam logic [2:0] E_LT = 3'b001;

`ifdef COMP_SIGNED_EN
    localparam logic [2:0] E_80_7F = E_LT;
    localparam logic [2:0] E_00_FF = E_GT;
    localparam logic [2:0] E_40_80 = E_GT;
`else
    localparam logic [2:0] E_80_7F = E_GT;
    localparam logic [2:0] E_00_FF = E_LT;
    localparam logic [2:0] E_40_80 = E_LT;
`endif

    typedef struct {
        logic [2:0] res;
        int         lat;
        int         startCycle;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy;
    logic       done;
    logic       resGt;
    logic       resEq;
    logic       resLt;

    exp_t expQ[$];
    int   cycleCnt = 0;
    int   busyRun = 0;
    int   totalCnt = 0;
    int   badCnt = 0;

    comp_serie #(
        .WIDTH (8),
        .CHUNK (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .M     (resGt),
        .igual (resEq),
        .m     (resLt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Count rising edges so latency can be measured from the start edge.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Compare one value and keep the running totals.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCnt++;
        if (actual !== expected) begin
            badCnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: on every done pulse pop the oldest expectation and compare.
    always @(negedge clk) begin
        exp_t e;
        if (busy) busyRun++;
        else busyRun = 0;
        if (done) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious done", {31'd0, done}, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("result", {29'd0, resGt, resEq, resLt}, {29'd0, e.res});
                checkOutput("latency", cycleCnt - e.startCycle, e.lat);
                checkOutput("busy length", busyRun, e.lat + 1);
            end
        end
    end

    // Drive one request from IDLE; optionally keep start high with a=0xFF for extra cycles.
    task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb,
                                 input logic [2:0] expRes, input int expLat, input int holdCycles);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle before start", {31'd0, busy}, 32'd0);
        a = va;
        b = vb;
        start = 1'b1;
        e.res = expRes;
        e.lat = expLat;
        e.startCycle = cycleCnt + 1;
        expQ.push_back(e);
        @(negedge clk);
        if (holdCycles > 0) begin
            a = 8'hFF;
            repeat (holdCycles) @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Bounded wait for the scoreboard to empty.
    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain timeout", expQ.size(), 0);
    endtask

    // Directed sequence.
    initial begin
        exp_t e;
        int   n;
        repeat (3) @(negedge clk);
        checkOutput("reset outputs", {27'd0, busy, done, resGt, resEq, resLt}, 32'd0);
        rst_n = 1'b1;

        applyStimulus(8'hA5, 8'hA5, E_EQ, 4, 0);
        waitDrain();
        @(negedge clk);
        checkOutput("result hold", {29'd0, resGt, resEq, resLt}, {29'd0, E_EQ});

        applyStimulus(8'h80, 8'h7F, E_80_7F, 1, 0);
        waitDrain();
        applyStimulus(8'h12, 8'h13, E_LT, 4, 2);
        waitDrain();
        applyStimulus(8'hFF, 8'hFE, E_GT, 4, 0);
        waitDrain();
        applyStimulus(8'h00, 8'hFF, E_00_FF, 1, 0);
        waitDrain();
        applyStimulus(8'h00, 8'h00, E_EQ, 4, 0);
        waitDrain();

        // Start during DONE is ignored; the following IDLE cycle accepts it.
        applyStimulus(8'h3C, 8'h34, E_GT, 3, 0);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done reached", {31'd0, done}, 32'd1);
        a = 8'h40;
        b = 8'h80;
        start = 1'b1;
        e.res = E_40_80;
        e.lat = 1;
        e.startCycle = cycleCnt + 2;
        expQ.push_back(e);
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        waitDrain();

        // Reset in the second RUN cycle aborts with no done pulse.
        @(negedge clk);
        a = 8'h12;
        b = 8'h13;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort outputs", {27'd0, busy, done, resGt, resEq, resLt}, 32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("no done after abort", {30'd0, busy, done}, 32'd0);

        applyStimulus(8'h12, 8'h13, E_LT, 4, 0);
        waitDrain();

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
